// File: rtl/w5300_pkg.sv
// Shared types and constants for the W5300 parallel-bus master and the
// blocks that sit on top of it.
package w5300_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } w5300_state_e;

    localparam int W5300_RST_LOW_CYC  = 200;
    localparam int W5300_RST_WAIT_CYC = 1000000;
    localparam int W5300_SETUP_CYC    = 1;
    localparam int W5300_STROBE_CYC   = 7;
    localparam int W5300_HOLD_CYC     = 1;
    localparam int W5300_RECOVER_CYC  = 3;

    // Common-register word addresses for the register-access engine.
    localparam logic [9:0] W5300_MR   = 10'h000;
    localparam logic [9:0] W5300_IR   = 10'h002;
    localparam logic [9:0] W5300_IMR  = 10'h004;
    localparam logic [9:0] W5300_SHAR = 10'h008;
    localparam logic [9:0] W5300_GAR  = 10'h010;
    localparam logic [9:0] W5300_SUBR = 10'h014;
    localparam logic [9:0] W5300_SIPR = 10'h018;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/w5300_int_sync.sv
// Two-flop synchroniser for the W5300 active-low interrupt; idles high so a
// reset never looks like a pending interrupt.
module w5300_int_sync (
    input  logic clk0,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/w5300_bus_ctrl.sv
// W5300 16-bit direct-bus master: power-up reset sequence plus single-word
// read/write cycles with registered pins and a shared phase timer.
//
// state       | meaning
// RST_LOW     | reset_n driven low
// RST_WAIT    | reset_n high, waiting for W5300 PLL lock
// IDLE        | req_ready high, waiting for a request
// SETUP       | cs_n/addr (and write data) valid ahead of the strobe
// STROBE      | rd_n or we_n low
// HOLD        | strobe released, cs_n/addr/data still held
// RECOVER     | bus released, rsp_valid pulses on entry
module w5300_bus_ctrl
    import w5300_pkg::*;
#(
    parameter int RST_LOW_CYC  = W5300_RST_LOW_CYC,
    parameter int RST_WAIT_CYC = W5300_RST_WAIT_CYC,
    parameter int SETUP_CYC    = W5300_SETUP_CYC,
    parameter int STROBE_CYC   = W5300_STROBE_CYC,
    parameter int HOLD_CYC     = W5300_HOLD_CYC,
    parameter int RECOVER_CYC  = W5300_RECOVER_CYC
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        init_done,
    output logic        irq,
    input  logic        int_n,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        data_oe,
    output logic [9:0]  addr,
    output logic        cs_n,
    output logic        rd_n,
    output logic        we_n,
    output logic        reset_n,
    output logic        rw_n
);

    localparam int MAX_CYC = max_int(max_int(max_int(RST_LOW_CYC, RST_WAIT_CYC),
                                             max_int(SETUP_CYC, STROBE_CYC)),
                                     max_int(HOLD_CYC, RECOVER_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    // Each phase counts down from N-1 so a value of 1 means a single cycle.
    localparam logic [CNT_W-1:0] LD_RST_LOW  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RST_WAIT = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETUP    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE   = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RECOVER  = CNT_W'(RECOVER_CYC - 1);

    w5300_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_lat_q, we_lat_d;
    logic             reset_n_q, reset_n_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             we_n_q, we_n_d;
    logic [9:0]       addr_q, addr_d;
    logic [15:0]      data_o_q, data_o_d;
    logic             data_oe_q, data_oe_d;
    logic             rw_n_q, rw_n_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             init_done_q, init_done_d;
    logic             cnt_zero;
    logic             int_sync;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - CNT_W'(1);
        we_lat_d    = we_lat_q;
        reset_n_d   = reset_n_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        we_n_d      = we_n_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        data_oe_d   = data_oe_q;
        rw_n_d      = rw_n_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_RST_LOW: begin
                if (cnt_zero) begin
                    state_d   = ST_RST_WAIT;
                    cnt_d     = LD_RST_WAIT;
                    reset_n_d = 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                    req_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (req_valid && req_ready_q) begin
                    state_d     = ST_SETUP;
                    cnt_d       = LD_SETUP;
                    req_ready_d = 1'b0;
                    we_lat_d    = req_we;
                    cs_n_d      = 1'b0;
                    addr_d      = req_addr;
                    rw_n_d      = ~req_we;
                    data_oe_d   = req_we;
                    data_o_d    = req_we ? req_wdata : data_o_q;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_STROBE;
                    rd_n_d  = we_lat_q;
                    we_n_d  = ~we_lat_q;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                    rd_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!we_lat_q) rsp_rdata_d = data_i;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d     = ST_RECOVER;
                    cnt_d       = LD_RECOVER;
                    cs_n_d      = 1'b1;
                    data_oe_d   = 1'b0;
                    rw_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_LOW;
                cnt_d   = LD_RST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST_LOW;
            cnt_q       <= LD_RST_LOW;
            we_lat_q    <= 1'b0;
            reset_n_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
            rw_n_q      <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_lat_q    <= we_lat_d;
            reset_n_q   <= reset_n_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            rw_n_q      <= rw_n_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    w5300_int_sync u_int_sync (
        .clk0    (clk0),
        .rst     (rst),
        .async_i (int_n),
        .sync_o  (int_sync)
    );

    assign irq       = ~int_sync;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;
    assign addr      = addr_q;
    assign cs_n      = cs_n_q;
    assign rd_n      = rd_n_q;
    assign we_n      = we_n_q;
    assign reset_n   = reset_n_q;
    assign rw_n      = rw_n_q;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Bench for w5300_bus_ctrl: a behavioural W5300 memory on the pins and a
// cycle-offset reference model of each bus access.
module tb_w5300_bus_ctrl;

    localparam int S = 1, T = 7, H = 1, R = 3;
    localparam int LOWC = 4, WAITC = 10;
    localparam int ACC = S + T + H + R + 1;

    logic        clk0 = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        init_done;
    logic        irq;
    logic        int_n = 1'b1;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        data_oe;
    logic [9:0]  addr;
    logic        cs_n, rd_n, we_n, reset_n, rw_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    w5300_bus_ctrl #(
        .RST_LOW_CYC(LOWC), .RST_WAIT_CYC(WAITC), .SETUP_CYC(S),
        .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R)
    ) dut (
        .clk0(clk0), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .irq(irq), .int_n(int_n), .data_i(data_i), .data_o(data_o),
        .data_oe(data_oe), .addr(addr), .cs_n(cs_n), .rd_n(rd_n), .we_n(we_n),
        .reset_n(reset_n), .rw_n(rw_n)
    );

    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc <= cyc + 1;

    // Behavioural W5300: captures writes on we_n rising, returns stored words
    // (or an address-derived pattern if never written) while rd_n is low.
    logic [15:0] dev_mem [0:1023];
    bit          dev_wr  [0:1023];
    logic [15:0] garbage = 16'h0;
    always @(posedge we_n) if (!rst && !cs_n) begin
        dev_mem[addr] <= data_o;
        dev_wr[addr]  <= 1'b1;
    end
    always @(negedge clk0) garbage <= 16'($urandom);
    assign data_i = (!cs_n && !rd_n) ?
                    (dev_wr[addr] ? dev_mem[addr] : (16'hA5A5 ^ {6'd0, addr})) : garbage;

    always @(negedge clk0) if (!rst) begin
        checks++;
        if (data_oe === 1'b1 && rw_n !== 1'b0) begin
            errors++;
            $display("FAIL dir_conflict t=%0t data_oe=%b rw_n=%b required rw_n=0", $time, data_oe, rw_n);
        end
    end

    // Reference model
    logic [15:0] exp_mem [0:1023];
    bit          exp_wr  [0:1023];
    logic [15:0] last_rd = 16'h0;

    function automatic logic [15:0] model_read(input logic [9:0] a);
        return exp_wr[a] ? exp_mem[a] : (16'hA5A5 ^ {6'd0, a});
    endfunction

    // {cs_n, rd_n, we_n, data_oe, rw_n, rsp_valid, req_ready} k cycles after accept
    function automatic logic [6:0] exp_ctl(input bit we, input int k);
        bit act, strb;
        act  = (k < S + T + H);
        strb = (k >= S) && (k < S + T);
        return {!act, !(strb && !we), !(strb && we), we && act, !(we && act),
                k == S + T + H, k == ACC - 1};
    endfunction

    logic [6:0]  tr_ctl   [0:ACC-1];
    logic [9:0]  tr_addr  [0:ACC-1];
    logic [15:0] tr_do    [0:ACC-1];
    logic [15:0] tr_rdata [0:ACC-1];
    int          acc_cyc;
    bit          acc_ok;

    task automatic run_access(input bit we, input logic [9:0] a, input logic [15:0] wd,
                              input int gap, input bit hold);
        int n;
        if (gap > 0) req_valid = 1'b0;
        repeat (gap + 1) @(negedge clk0);
        req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk0);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
            req_valid = 1'b0; acc_ok = 1'b0;
            return;
        end
        @(posedge clk0); #1;
        acc_cyc = cyc; acc_ok = 1'b1;
        if (!hold) req_valid = 1'b0;
        for (int k = 0; k < ACC; k++) begin
            if (k > 0) begin @(posedge clk0); #1; end
            tr_ctl[k]   = {cs_n, rd_n, we_n, data_oe, rw_n, rsp_valid, req_ready};
            tr_addr[k]  = addr;
            tr_do[k]    = data_o;
            tr_rdata[k] = rsp_rdata;
        end
    endtask

    task automatic test_reset();
        int n, m;
        bit bad;
        repeat (3) @(negedge clk0);
        checks++;
        if ({reset_n, cs_n, rd_n, we_n, data_oe, rw_n, req_ready, rsp_valid, init_done, irq} !== 10'b0111010000) begin
            errors++;
            $display("FAIL reset_ctl got %b required 0111010000",
                     {reset_n, cs_n, rd_n, we_n, data_oe, rw_n, req_ready, rsp_valid, init_done, irq});
        end
        checks++;
        if ({addr, data_o, rsp_rdata} !== 42'd0) begin
            errors++;
            $display("FAIL reset_data addr=%h data_o=%h rsp_rdata=%h required 0", addr, data_o, rsp_rdata);
        end
        rst = 1'b0;
        n = 0; bad = 1'b0;
        do begin
            @(posedge clk0); #1; n++;
            if (req_ready !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
        end while (reset_n !== 1'b1 && n < 100);
        checks++;
        if (n != LOWC) begin errors++; $display("FAIL reset_low_len got %0d required %0d", n, LOWC); end
        m = 0;
        do begin
            @(posedge clk0); #1; m++;
            if (init_done !== 1'b1 && req_ready !== 1'b0) bad = 1'b1;
        end while (init_done !== 1'b1 && m < 100);
        checks++;
        if (m != WAITC) begin errors++; $display("FAIL init_wait_len got %0d required %0d", m, WAITC); end
        checks++;
        if (bad) begin errors++; $display("FAIL ready_during_init got early req_ready/init_done required 0"); end
        checks++;
        if ({req_ready, reset_n} !== 2'b11) begin
            errors++; $display("FAIL ready_after_init got %b required 11", {req_ready, reset_n});
        end
    endtask

    task automatic test_write();
        int cs_lo, we_lo, rd_lo, rsp_k;
        bit dbad;
        run_access(1'b1, 10'h000, 16'h3A80, 0, 1'b0);
        if (acc_ok) begin
            cs_lo = 0; we_lo = 0; rd_lo = 0; rsp_k = -1; dbad = 1'b0;
            for (int k = 0; k < ACC; k++) begin
                if (!tr_ctl[k][6]) begin
                    cs_lo++;
                    if (tr_do[k] !== 16'h3A80 || tr_ctl[k][3:2] !== 2'b10) dbad = 1'b1;
                end
                if (!tr_ctl[k][4]) we_lo++;
                if (!tr_ctl[k][5]) rd_lo++;
                if (tr_ctl[k][1] && rsp_k < 0) rsp_k = k;
            end
            checks++;
            if (cs_lo != 9) begin errors++; $display("FAIL wr_cs_low got %0d required 9", cs_lo); end
            checks++;
            if (we_lo != 7) begin errors++; $display("FAIL wr_we_low got %0d required 7", we_lo); end
            checks++;
            if (rd_lo != 0) begin errors++; $display("FAIL wr_rd_low got %0d required 0", rd_lo); end
            checks++;
            if (dbad) begin errors++; $display("FAIL wr_data_dir got bad data_o/oe/rw_n required 3a80/1/0"); end
            checks++;
            if (rsp_k != 9) begin errors++; $display("FAIL wr_rsp_latency got %0d required 9", rsp_k); end
            checks++;
            if (tr_rdata[9] !== last_rd) begin
                errors++; $display("FAIL wr_rdata_hold got %h required %h", tr_rdata[9], last_rd);
            end
            exp_mem[10'h000] = 16'h3A80; exp_wr[10'h000] = 1'b1;
        end
    endtask

    task automatic test_read();
        bit bad;
        run_access(1'b1, 10'h0FE, 16'h5300, 1, 1'b0);
        if (acc_ok) begin exp_mem[10'h0FE] = 16'h5300; exp_wr[10'h0FE] = 1'b1; end
        run_access(1'b0, 10'h0FE, 16'hFFFF, 2, 1'b0);
        if (acc_ok) begin
            bad = 1'b0;
            for (int k = 0; k < ACC; k++)
                if (tr_ctl[k][3:2] !== 2'b01 || tr_ctl[k][4] !== 1'b1) bad = 1'b1;
            checks++;
            if (bad) begin errors++; $display("FAIL rd_dir got data_oe/rw_n/we_n active required 0/1/1"); end
            checks++;
            if (tr_ctl[9][1] !== 1'b1 || tr_rdata[9] !== 16'h5300) begin
                errors++;
                $display("FAIL rd_data got rsp_valid=%b rdata=%h required 1/5300", tr_ctl[9][1], tr_rdata[9]);
            end
            last_rd = 16'h5300;
        end
    endtask

    task automatic test_back_to_back();
        int a1, hi;
        logic [9:0]  a;
        logic [15:0] wd;
        a = 10'($urandom); wd = 16'($urandom);
        run_access(1'b1, a, wd, 0, 1'b1);
        a1 = acc_cyc;
        hi = 0;
        for (int k = 0; k < ACC; k++) if (tr_ctl[k][6]) hi++;
        exp_mem[a] = wd; exp_wr[a] = 1'b1;
        run_access(1'b0, a, 16'h0, 0, 1'b1);
        req_valid = 1'b0;
        checks++;
        if (acc_cyc - a1 != ACC) begin errors++; $display("FAIL b2b_spacing got %0d required %0d", acc_cyc - a1, ACC); end
        checks++;
        if (hi != R + 1) begin errors++; $display("FAIL b2b_cs_gap got %0d required %0d", hi, R + 1); end
        checks++;
        if (tr_rdata[9] !== wd) begin errors++; $display("FAIL b2b_rdata got %h required %h", tr_rdata[9], wd); end
        last_rd = wd;
    endtask

    task automatic test_random();
        bit          we;
        logic [9:0]  a;
        logic [15:0] wd, er;
        logic [9:0]  used [$];
        int          gap, prev;
        prev = -1000;
        for (int i = 0; i < 24; i++) begin
            we  = 1'($urandom_range(0, 1));
            a   = (used.size() > 0 && $urandom_range(0, 1) == 1) ?
                  used[$urandom_range(0, used.size() - 1)] : 10'($urandom);
            wd  = 16'($urandom);
            gap = $urandom_range(0, 2);
            er  = we ? last_rd : model_read(a);
            run_access(we, a, wd, gap, 1'b0);
            if (acc_ok) begin
                for (int k = 0; k < ACC; k++) begin
                    checks++;
                    if (tr_ctl[k] !== exp_ctl(we, k)) begin
                        errors++;
                        $display("FAIL rnd_ctl i=%0d k=%0d got %b required %b", i, k, tr_ctl[k], exp_ctl(we, k));
                    end
                    if (k < S + T + H) begin
                        checks++;
                        if (tr_addr[k] !== a || (we && tr_do[k] !== wd)) begin
                            errors++;
                            $display("FAIL rnd_bus i=%0d k=%0d got addr=%h data_o=%h required %h/%h",
                                     i, k, tr_addr[k], tr_do[k], a, wd);
                        end
                    end
                end
                checks++;
                if (tr_rdata[S + T + H] !== er) begin
                    errors++; $display("FAIL rnd_rdata i=%0d got %h required %h", i, tr_rdata[S + T + H], er);
                end
                if (prev >= 0) begin
                    checks++;
                    if (acc_cyc - prev != ACC + gap) begin
                        errors++; $display("FAIL rnd_spacing i=%0d got %0d required %0d", i, acc_cyc - prev, ACC + gap);
                    end
                end
                prev = acc_cyc;
                if (we) begin exp_mem[a] = wd; exp_wr[a] = 1'b1; used.push_back(a); end
                else last_rd = er;
            end
        end
    endtask

    task automatic test_rst_mid();
        int n, m;
        bit rsp_seen;
        @(negedge clk0);
        req_we = 1'b1; req_addr = 10'h3C3; req_wdata = 16'hBEEF; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk0); n++; end
        @(posedge clk0); #1; req_valid = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        checks++;
        if (we_n !== 1'b0) begin errors++; $display("FAIL mid_in_strobe got we_n=%b required 0", we_n); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({we_n, cs_n, data_oe, reset_n, rw_n, req_ready, init_done} !== 7'b1100100) begin
            errors++;
            $display("FAIL mid_async_reset got %b required 1100100",
                     {we_n, cs_n, data_oe, reset_n, rw_n, req_ready, init_done});
        end
        rsp_seen = 1'b0;
        repeat (3) begin @(negedge clk0); if (rsp_valid !== 1'b0) rsp_seen = 1'b1; end
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk0); #1; n++;
            if (rsp_valid !== 1'b0) rsp_seen = 1'b1;
        end while (reset_n !== 1'b1 && n < 100);
        checks++;
        if (n != LOWC) begin errors++; $display("FAIL mid_reset_low got %0d required %0d", n, LOWC); end
        m = 0;
        do begin
            @(posedge clk0); #1; m++;
            if (rsp_valid !== 1'b0) rsp_seen = 1'b1;
        end while (init_done !== 1'b1 && m < 100);
        checks++;
        if (m != WAITC) begin errors++; $display("FAIL mid_init_wait got %0d required %0d", m, WAITC); end
        checks++;
        if (rsp_seen) begin errors++; $display("FAIL mid_no_rsp got rsp_valid=1 required 0"); end
        last_rd = 16'h0;
        checks++;
        if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL mid_rdata_reset got %h required 0000", rsp_rdata); end
    endtask

    task automatic test_irq();
        int len;
        logic exp_irq;
        for (int p = 0; p < 2; p++) begin
            len = (p == 0) ? 5 : $urandom_range(1, 6);
            @(negedge clk0); int_n = 1'b0;
            for (int j = 1; j <= len + 4; j++) begin
                @(posedge clk0); #1;
                exp_irq = (j >= 2) && (j <= len + 1);
                checks++;
                if (irq !== exp_irq) begin
                    errors++; $display("FAIL irq_sync len=%0d j=%0d got %b required %b", len, j, irq, exp_irq);
                end
                @(negedge clk0);
                if (j == len) int_n = 1'b1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rst_mid();
        test_random();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
